// File: rtl/stc_acq_sequencer.sv
// Acquisition/track sequencer for the STC carrier loop: clear -> frequency pull-in ->
// phase pull-in -> track, with timeout retries and fallback to frequency acquisition.
module stc_acq_sequencer #(
  parameter int CLEAR_CYCLES = 16,
  parameter int FREQ_QUAL    = 8,
  parameter int PHASE_DWELL  = 1024
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clkEn,
  input  logic        i_enable,
  input  logic        i_freqAcquired,
  input  logic [11:0] i_avgFreqError,
  input  logic [11:0] i_phaseThreshold,
  input  logic [15:0] i_freqTimeout,
  input  logic [4:0]  i_acqLeadExp,
  input  logic [4:0]  i_acqLagExp,
  input  logic [4:0]  i_trkLeadExp,
  input  logic [4:0]  i_trkLagExp,
  output logic        o_clearAccum,
  output logic        o_zeroPhaseError,
  output logic [4:0]  o_leadExp,
  output logic [4:0]  o_phaseLagExp,
  output logic        o_carrierLock,
  output logic        o_timeoutPulse,
  output logic [3:0]  o_retryCount,
  output logic [2:0]  o_seqState
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FREQ  = 3'd2,
    S_PHASE = 3'd3,
    S_TRACK = 3'd4
  } state_t;

  localparam logic [15:0] L_CLR_LAST = 16'(CLEAR_CYCLES - 1);
  localparam logic [15:0] L_QUAL     = 16'(FREQ_QUAL);
  localparam logic [15:0] L_DWELL    = 16'(PHASE_DWELL);

  state_t      r_state;
  logic [15:0] r_clrCnt, r_qual, r_tmo, r_dwell;
  logic [3:0]  r_retry;
  logic        r_clearAccum, r_zeroPhaseError, r_carrierLock, r_timeoutPulse;
  logic [4:0]  r_leadExp, r_phaseLagExp;

  state_t      w_next;
  logic [15:0] w_clrCnt, w_qual, w_tmo, w_dwell;
  logic [3:0]  w_retry;
  logic        w_tmoHit;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    w_next   = r_state;
    w_clrCnt = r_clrCnt;
    w_qual   = r_qual;
    w_tmo    = r_tmo;
    w_dwell  = r_dwell;
    w_retry  = r_retry;
    w_tmoHit = 1'b0;
    if (!i_enable) begin
      w_next   = S_IDLE;
      w_clrCnt = '0;
      w_qual   = '0;
      w_tmo    = '0;
      w_dwell  = '0;
      w_retry  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next   = S_CLEAR;
          w_clrCnt = '0;
          w_retry  = '0;
        end
        S_CLEAR: begin
          if (r_clrCnt >= L_CLR_LAST) begin
            w_next   = S_FREQ;
            w_clrCnt = '0;
            w_qual   = '0;
            w_tmo    = '0;
            w_dwell  = '0;
          end else begin
            w_clrCnt = satInc(r_clrCnt);
          end
        end
        S_FREQ: begin
          if (i_clkEn) begin
            w_qual = i_freqAcquired ? satInc(r_qual) : '0;
            w_tmo  = satInc(r_tmo);
            // Qualified lock takes precedence over a timeout landing on the same strobe.
            if (w_qual >= L_QUAL) begin
              w_next  = S_PHASE;
              w_dwell = '0;
            end else if ((i_freqTimeout != 16'd0) && (w_tmo >= i_freqTimeout)) begin
              w_next   = S_CLEAR;
              w_clrCnt = '0;
              w_tmoHit = 1'b1;
              w_retry  = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
            end
          end
        end
        S_PHASE: begin
          if (i_clkEn) begin
            if (!i_freqAcquired) begin
              w_next = S_FREQ;
              w_qual = '0;
              w_tmo  = '0;
            end else begin
              w_dwell = (i_avgFreqError <= i_phaseThreshold) ? satInc(r_dwell) : '0;
              if (w_dwell >= L_DWELL) w_next = S_TRACK;
            end
          end
        end
        S_TRACK: begin
          // Lock loss keeps the accumulator; only the frequency qualifiers restart.
          if (i_clkEn && !i_freqAcquired) begin
            w_next = S_FREQ;
            w_qual = '0;
            w_tmo  = '0;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_clrCnt         <= '0;
      r_qual           <= '0;
      r_tmo            <= '0;
      r_dwell          <= '0;
      r_retry          <= '0;
      r_timeoutPulse   <= 1'b0;
      r_clearAccum     <= 1'b1;
      r_zeroPhaseError <= 1'b1;
      r_leadExp        <= '0;
      r_phaseLagExp    <= '0;
      r_carrierLock    <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_clrCnt       <= w_clrCnt;
      r_qual         <= w_qual;
      r_tmo          <= w_tmo;
      r_dwell        <= w_dwell;
      r_retry        <= w_retry;
      r_timeoutPulse <= w_tmoHit;
      case (w_next)
        S_CLEAR: begin
          r_clearAccum     <= 1'b1;
          r_zeroPhaseError <= 1'b1;
          r_leadExp        <= i_acqLeadExp;
          r_phaseLagExp    <= i_acqLagExp;
          r_carrierLock    <= 1'b0;
        end
        S_FREQ: begin
          r_clearAccum     <= 1'b0;
          r_zeroPhaseError <= 1'b1;
          r_leadExp        <= i_acqLeadExp;
          r_phaseLagExp    <= i_acqLagExp;
          r_carrierLock    <= 1'b0;
        end
        S_PHASE: begin
          r_clearAccum     <= 1'b0;
          r_zeroPhaseError <= 1'b0;
          r_leadExp        <= i_acqLeadExp;
          r_phaseLagExp    <= i_acqLagExp;
          r_carrierLock    <= 1'b0;
        end
        S_TRACK: begin
          r_clearAccum     <= 1'b0;
          r_zeroPhaseError <= 1'b0;
          r_leadExp        <= i_trkLeadExp;
          r_phaseLagExp    <= i_trkLagExp;
          r_carrierLock    <= 1'b1;
        end
        default: begin
          r_clearAccum     <= 1'b1;
          r_zeroPhaseError <= 1'b1;
          r_leadExp        <= '0;
          r_phaseLagExp    <= '0;
          r_carrierLock    <= 1'b0;
        end
      endcase
    end
  end

  assign o_clearAccum     = r_clearAccum;
  assign o_zeroPhaseError = r_zeroPhaseError;
  assign o_leadExp        = r_leadExp;
  assign o_phaseLagExp    = r_phaseLagExp;
  assign o_carrierLock    = r_carrierLock;
  assign o_timeoutPulse   = r_timeoutPulse;
  assign o_retryCount     = r_retry;
  assign o_seqState       = r_state;

endmodule

// File: tb/tb_stc_acq_sequencer.sv
// Self-checking bench for stc_acq_sequencer: scenario tasks with randomized strobes,
// expectations derived from strobe counting against the sequencer's state rules.
module tb_stc_acq_sequencer;

  logic        clk = 1'b0;
  logic        reset, clkEn, enable, freqAcquired;
  logic [11:0] avgFreqError, phaseThreshold;
  logic [15:0] freqTimeout;
  logic [4:0]  acqLeadExp, acqLagExp, trkLeadExp, trkLagExp;
  logic        o_clearAccum, o_zeroPhaseError, o_carrierLock, o_timeoutPulse;
  logic [4:0]  o_leadExp, o_phaseLagExp;
  logic [3:0]  o_retryCount;
  logic [2:0]  o_seqState;
  logic [20:0] actVec;

  int checks = 0;
  int failures = 0;

  localparam int ST_IDLE = 0, ST_CLEAR = 1, ST_FREQ = 2, ST_PHASE = 3, ST_TRACK = 4;

  stc_acq_sequencer dut (
    .i_clk(clk), .i_reset(reset), .i_clkEn(clkEn), .i_enable(enable),
    .i_freqAcquired(freqAcquired), .i_avgFreqError(avgFreqError),
    .i_phaseThreshold(phaseThreshold), .i_freqTimeout(freqTimeout),
    .i_acqLeadExp(acqLeadExp), .i_acqLagExp(acqLagExp),
    .i_trkLeadExp(trkLeadExp), .i_trkLagExp(trkLagExp),
    .o_clearAccum(o_clearAccum), .o_zeroPhaseError(o_zeroPhaseError),
    .o_leadExp(o_leadExp), .o_phaseLagExp(o_phaseLagExp),
    .o_carrierLock(o_carrierLock), .o_timeoutPulse(o_timeoutPulse),
    .o_retryCount(o_retryCount), .o_seqState(o_seqState)
  );

  always #5 clk = ~clk;

  assign actVec = {o_clearAccum, o_zeroPhaseError, o_leadExp, o_phaseLagExp,
                   o_carrierLock, o_timeoutPulse, o_retryCount, o_seqState};

  // Expected output word for a state, from the per-state output table.
  function automatic logic [20:0] expVec(input int st, input int retry, input logic pulse);
    logic [4:0] le, la;
    logic ca, zp, cl;
    le = '0; la = '0; ca = 1'b1; zp = 1'b1; cl = 1'b0;
    case (st)
      ST_CLEAR: begin le = acqLeadExp; la = acqLagExp; end
      ST_FREQ:  begin ca = 1'b0; le = acqLeadExp; la = acqLagExp; end
      ST_PHASE: begin ca = 1'b0; zp = 1'b0; le = acqLeadExp; la = acqLagExp; end
      ST_TRACK: begin ca = 1'b0; zp = 1'b0; le = trkLeadExp; la = trkLagExp; cl = 1'b1; end
      default: ;
    endcase
    return {ca, zp, le, la, cl, pulse, 4'(retry), 3'(st)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; clkEn = 1'b1; freqAcquired = 1'b1;
    tick(); tick();
    checks++;
    if (actVec !== expVec(ST_IDLE, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL reset_hold got=%h exp=%h", actVec, expVec(ST_IDLE, 0, 1'b0));
    end
    reset = 1'b0; enable = 1'b0;
    tick();
    checks++;
    if (actVec !== expVec(ST_IDLE, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL idle_disabled got=%h exp=%h", actVec, expVec(ST_IDLE, 0, 1'b0));
    end
  endtask

  task automatic test_acquire();
    int n, st;
    acqLeadExp = 5'($urandom); acqLagExp = 5'($urandom);
    trkLeadExp = acqLeadExp ^ 5'($urandom_range(1, 31));
    trkLagExp  = acqLagExp ^ 5'($urandom_range(1, 31));
    phaseThreshold = 12'($urandom_range(200, 4000));
    avgFreqError = '0; freqTimeout = '0; freqAcquired = 1'b1; enable = 1'b1;
    for (int i = 0; i < 16; i++) begin
      clkEn = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (actVec !== expVec(ST_CLEAR, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL clear_hold i=%0d got=%h exp=%h", i, actVec, expVec(ST_CLEAR, 0, 1'b0));
      end
    end
    clkEn = 1'($urandom_range(0, 1));
    tick();
    checks++;
    if (actVec !== expVec(ST_FREQ, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL enter_freq got=%h exp=%h", actVec, expVec(ST_FREQ, 0, 1'b0));
    end
    n = 0; st = ST_FREQ;
    while (st == ST_FREQ) begin
      clkEn = 1'($urandom_range(0, 1));
      tick();
      if (clkEn) n++;
      if (n == 8) st = ST_PHASE;
      checks++;
      if (actVec !== expVec(st, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL freq_qual n=%0d got=%h exp=%h", n, actVec, expVec(st, 0, 1'b0));
      end
    end
    n = 0;
    while (st == ST_PHASE) begin
      clkEn = 1'($urandom_range(0, 1));
      avgFreqError = ($urandom_range(0, 3) == 0) ? phaseThreshold
                                                 : 12'($urandom_range(0, int'(phaseThreshold)));
      tick();
      if (clkEn) n++;
      if (n == 1024) st = ST_TRACK;
      checks++;
      if (actVec !== expVec(st, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL phase_dwell n=%0d got=%h exp=%h", n, actVec, expVec(st, 0, 1'b0));
      end
    end
    for (int i = 0; i < 5; i++) begin
      clkEn = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (actVec !== expVec(ST_TRACK, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL track_hold got=%h exp=%h", actVec, expVec(ST_TRACK, 0, 1'b0));
      end
    end
  endtask

  task automatic test_lock_loss();
    int exp;
    freqAcquired = 1'b0; clkEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (actVec !== expVec(ST_TRACK, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL trk_no_strobe got=%h exp=%h", actVec, expVec(ST_TRACK, 0, 1'b0));
      end
    end
    clkEn = 1'b1;
    tick();
    checks++;
    if (actVec !== expVec(ST_FREQ, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL trk_lock_loss got=%h exp=%h", actVec, expVec(ST_FREQ, 0, 1'b0));
    end
    // Five qualifying strobes, one break, then a full run of eight.
    for (int i = 0; i < 14; i++) begin
      freqAcquired = (i != 5); clkEn = 1'b1;
      tick();
      exp = (i == 13) ? ST_PHASE : ST_FREQ;
      checks++;
      if (actVec !== expVec(exp, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL requal i=%0d got=%h exp=%h", i, actVec, expVec(exp, 0, 1'b0));
      end
    end
    freqAcquired = 1'b0;
    tick();
    checks++;
    if (actVec !== expVec(ST_FREQ, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL phase_drop got=%h exp=%h", actVec, expVec(ST_FREQ, 0, 1'b0));
    end
    freqAcquired = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i == 8) ? ST_PHASE : ST_FREQ;
      checks++;
      if (actVec !== expVec(exp, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL requal2 i=%0d got=%h exp=%h", i, actVec, expVec(exp, 0, 1'b0));
      end
    end
  endtask

  task automatic test_dwell_reset();
    int n, st;
    freqAcquired = 1'b1; n = 0; st = ST_PHASE;
    while (n < 1000) begin
      clkEn = 1'($urandom_range(0, 1));
      avgFreqError = clkEn ? 12'($urandom_range(0, int'(phaseThreshold))) : 12'($urandom);
      tick();
      if (clkEn) n++;
      checks++;
      if (actVec !== expVec(ST_PHASE, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL dwell_pre n=%0d got=%h exp=%h", n, actVec, expVec(ST_PHASE, 0, 1'b0));
      end
    end
    clkEn = 1'b1; avgFreqError = phaseThreshold + 12'd1;
    tick();
    checks++;
    if (actVec !== expVec(ST_PHASE, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL dwell_break got=%h exp=%h", actVec, expVec(ST_PHASE, 0, 1'b0));
    end
    n = 0;
    while (st == ST_PHASE) begin
      clkEn = 1'($urandom_range(0, 1));
      avgFreqError = clkEn ? 12'($urandom_range(0, int'(phaseThreshold))) : 12'($urandom);
      tick();
      if (clkEn) n++;
      if (n == 1024) st = ST_TRACK;
      checks++;
      if (actVec !== expVec(st, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL dwell_post n=%0d got=%h exp=%h", n, actVec, expVec(st, 0, 1'b0));
      end
    end
  endtask

  task automatic test_enable_track();
    enable = 1'b0;
    for (int i = 0; i < 2; i++) begin
      clkEn = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if (actVec !== expVec(ST_IDLE, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL track_disable i=%0d got=%h exp=%h", i, actVec, expVec(ST_IDLE, 0, 1'b0));
      end
    end
  endtask

  task automatic test_timeout();
    int n, retry;
    logic done;
    freqTimeout = 16'd100; freqAcquired = 1'b0; enable = 1'b1; retry = 0;
    tick();
    checks++;
    if (actVec !== expVec(ST_CLEAR, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL to_enter_clear got=%h exp=%h", actVec, expVec(ST_CLEAR, 0, 1'b0));
    end
    for (int r = 0; r < 17; r++) begin
      for (int i = 1; i < 16; i++) begin
        tick();
        checks++;
        if (actVec !== expVec(ST_CLEAR, retry, 1'b0)) begin
          failures++;
          $display("[TB] FAIL to_clear r=%0d got=%h exp=%h", r, actVec, expVec(ST_CLEAR, retry, 1'b0));
        end
      end
      tick();
      checks++;
      if (actVec !== expVec(ST_FREQ, retry, 1'b0)) begin
        failures++;
        $display("[TB] FAIL to_freq r=%0d got=%h exp=%h", r, actVec, expVec(ST_FREQ, retry, 1'b0));
      end
      n = 0; done = 1'b0;
      while (!done) begin
        clkEn = ($urandom_range(0, 3) != 0);
        tick();
        if (clkEn) n++;
        checks++;
        if (n == 100) begin
          retry = (retry == 15) ? 15 : retry + 1;
          done = 1'b1;
          if (actVec !== expVec(ST_CLEAR, retry, 1'b1)) begin
            failures++;
            $display("[TB] FAIL to_pulse r=%0d got=%h exp=%h", r, actVec, expVec(ST_CLEAR, retry, 1'b1));
          end
        end else if (actVec !== expVec(ST_FREQ, retry, 1'b0)) begin
          failures++;
          $display("[TB] FAIL to_wait r=%0d n=%0d got=%h exp=%h", r, n, actVec, expVec(ST_FREQ, retry, 1'b0));
        end
      end
    end
  endtask

  task automatic test_enable_clear();
    tick();
    checks++;
    if (actVec !== expVec(ST_CLEAR, 15, 1'b0)) begin
      failures++;
      $display("[TB] FAIL clear_sat got=%h exp=%h", actVec, expVec(ST_CLEAR, 15, 1'b0));
    end
    enable = 1'b0;
    tick();
    checks++;
    if (actVec !== expVec(ST_IDLE, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL clear_disable got=%h exp=%h", actVec, expVec(ST_IDLE, 0, 1'b0));
    end
    enable = 1'b1;
    tick();
    checks++;
    if (actVec !== expVec(ST_CLEAR, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL clear_restart got=%h exp=%h", actVec, expVec(ST_CLEAR, 0, 1'b0));
    end
  endtask

  task automatic test_tie();
    int exp;
    freqTimeout = 16'd8; freqAcquired = 1'b1; clkEn = 1'b1;
    for (int i = 1; i < 16; i++) tick();
    tick();
    checks++;
    if (actVec !== expVec(ST_FREQ, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL tie_enter got=%h exp=%h", actVec, expVec(ST_FREQ, 0, 1'b0));
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i == 8) ? ST_PHASE : ST_FREQ;
      checks++;
      if (actVec !== expVec(exp, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL tie i=%0d got=%h exp=%h", i, actVec, expVec(exp, 0, 1'b0));
      end
    end
  endtask

  task automatic test_no_timeout_reset();
    enable = 1'b0;
    tick();
    enable = 1'b1; freqTimeout = 16'd0; freqAcquired = 1'b0; clkEn = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if (actVec !== expVec(ST_CLEAR, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL nt_clear got=%h exp=%h", actVec, expVec(ST_CLEAR, 0, 1'b0));
    end
    for (int i = 0; i < 301; i++) begin
      tick();
      checks++;
      if (actVec !== expVec(ST_FREQ, 0, 1'b0)) begin
        failures++;
        $display("[TB] FAIL no_timeout i=%0d got=%h exp=%h", i, actVec, expVec(ST_FREQ, 0, 1'b0));
      end
    end
    reset = 1'b1;
    tick();
    checks++;
    if (actVec !== expVec(ST_IDLE, 0, 1'b0)) begin
      failures++;
      $display("[TB] FAIL reset_in_freq got=%h exp=%h", actVec, expVec(ST_IDLE, 0, 1'b0));
    end
    reset = 1'b0; enable = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clkEn = 1'b0; freqAcquired = 1'b0;
    avgFreqError = '0; phaseThreshold = '0; freqTimeout = '0;
    acqLeadExp = '0; acqLagExp = '0; trkLeadExp = '0; trkLagExp = '0;
    test_reset();
    test_acquire();
    test_lock_loss();
    test_dwell_reset();
    test_enable_track();
    test_timeout();
    test_enable_clear();
    test_tie();
    test_no_timeout_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
